nv_nvdla_dmaif_wr_router: RTL and testbench

- Parametrised write-DMA request router and completion sequencer for NUM_IF memory interfaces (MCIF, CVIF, further ports).
- Sits between a client write engine and the NOC write ports.
- Routes each request to the interface selected by reg2dp_dst_ram_type, one skid buffer per interface.
- Tracks up to ACK_DEPTH outstanding ack-required requests in issue order and emits one completion pulse per acknowledged request, in issue order across interfaces.

---
 rtl/nv_nvdla_dmaif_wr_router_if.sv | 38 +++
 rtl/nv_nvdla_dmaif_wr_router.sv | 159 +++++++++++++++
 tb/tb_nv_nvdla_dmaif_wr_router.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nv_nvdla_dmaif_wr_router_if.sv
// Bus bundle for the write-DMA router: client request side, per-interface
// NOC request/completion side and the ordered completion/status outputs.
interface nv_nvdla_dmaif_wr_router_if #(
    parameter int NUM_IF    = 2,
    parameter int PD_W      = 515,
    parameter int ACK_DEPTH = 4
);
    localparam int IF_W  = (NUM_IF > 1) ? $clog2(NUM_IF) : 1;
    localparam int OCC_W = $clog2(ACK_DEPTH) + 1;

    logic [IF_W-1:0]        reg2dp_dst_ram_type;
    logic [PD_W-1:0]        dmaif_wr_req_pd;
    logic                   dmaif_wr_req_pvld;
    logic                   dmaif_wr_req_require_ack;
    logic                   dmaif_wr_req_prdy;
    logic [NUM_IF*PD_W-1:0] if_wr_req_pd;
    logic [NUM_IF-1:0]      if_wr_req_valid;
    logic [NUM_IF-1:0]      if_wr_req_ready;
    logic [NUM_IF-1:0]      if_wr_rsp_complete;
    logic                   dmaif_wr_rsp_complete;
    logic [OCC_W-1:0]       dmaif_wr_ack_pending;
    logic                   dmaif_wr_err;

    // Environment view: client write engine plus the NOC write ports.
    modport master (
        output reg2dp_dst_ram_type, dmaif_wr_req_pd, dmaif_wr_req_pvld,
               dmaif_wr_req_require_ack, if_wr_req_ready, if_wr_rsp_complete,
        input  dmaif_wr_req_prdy, if_wr_req_pd, if_wr_req_valid,
               dmaif_wr_rsp_complete, dmaif_wr_ack_pending, dmaif_wr_err
    );

    modport slave (
        input  reg2dp_dst_ram_type, dmaif_wr_req_pd, dmaif_wr_req_pvld,
               dmaif_wr_req_require_ack, if_wr_req_ready, if_wr_rsp_complete,
        output dmaif_wr_req_prdy, if_wr_req_pd, if_wr_req_valid,
               dmaif_wr_rsp_complete, dmaif_wr_ack_pending, dmaif_wr_err
    );
endinterface

// File: rtl/nv_nvdla_dmaif_wr_router.sv
// Write-DMA request router with one skid buffer per memory interface and an
// in-order completion sequencer driven by a FIFO of ack-required destinations.
module nv_nvdla_dmaif_wr_router #(
    parameter int NUM_IF    = 2,
    parameter int PD_W      = 515,
    parameter int ACK_DEPTH = 4,
    parameter int CNT_W     = 4
) (
    input  logic nvdla_core_clk,
    input  logic nvdla_core_rst,
    nv_nvdla_dmaif_wr_router_if.slave bus
);
    localparam int IF_W  = (NUM_IF > 1) ? $clog2(NUM_IF) : 1;
    localparam int PTR_W = $clog2(ACK_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [IF_W:0] NUM_IF_L = (IF_W+1)'(NUM_IF);

    logic [IF_W-1:0]   sel;
    logic              sel_ok, sel_rdy, prdy, accept, push, rel;
    logic              fifo_full, fifo_empty, head_avail;
    logic [IF_W-1:0]   head;
    logic [NUM_IF-1:0] push_vec, rel_vec, avail;

    logic [NUM_IF-1:0] vld_q, vld_d, skid_vld_q, skid_vld_d;
    logic [PD_W-1:0]   pd_q [NUM_IF];
    logic [PD_W-1:0]   pd_d [NUM_IF];
    logic [PD_W-1:0]   skid_pd_q [NUM_IF];
    logic [PD_W-1:0]   skid_pd_d [NUM_IF];

    logic [IF_W-1:0]   ack_mem_q [ACK_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic [NUM_IF-1:0] comp_q;
    logic [CNT_W-1:0]  cnt_q [NUM_IF];
    logic [CNT_W-1:0]  cnt_d [NUM_IF];
    logic              err_q, err_d, rsp_q;

    assign sel        = bus.reg2dp_dst_ram_type;
    assign sel_ok     = {1'b0, sel} < NUM_IF_L;
    assign fifo_full  = (occ_q == OCC_W'(ACK_DEPTH));
    assign fifo_empty = (occ_q == '0);
    assign head       = ack_mem_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel_rdy    = 1'b0;
        push_vec   = '0;
        rel_vec    = '0;
        avail      = '0;
        head_avail = 1'b0;
        for (int i = 0; i < NUM_IF; i++) begin
            avail[i] = comp_q[i] | (cnt_q[i] != '0);
            if (sel == IF_W'(i)) sel_rdy = !skid_vld_q[i];
            if (head == IF_W'(i)) head_avail = avail[i];
        end
        // prdy is forced low in reset so every output reads 0 while rst is held.
        prdy   = !nvdla_core_rst && sel_ok && sel_rdy &&
                 !(bus.dmaif_wr_req_require_ack && fifo_full);
        accept = bus.dmaif_wr_req_pvld && prdy;
        push   = accept && bus.dmaif_wr_req_require_ack;
        rel    = !fifo_empty && head_avail;
        for (int i = 0; i < NUM_IF; i++) begin
            push_vec[i] = accept && (sel == IF_W'(i));
            rel_vec[i]  = rel && (head == IF_W'(i));
        end
    end

    // Output register plus one skid entry; ready upstream depends only on the skid flag.
    always_comb begin
        vld_d      = vld_q;
        skid_vld_d = skid_vld_q;
        pd_d       = pd_q;
        skid_pd_d  = skid_pd_q;
        for (int i = 0; i < NUM_IF; i++) begin
            if (!vld_q[i] || bus.if_wr_req_ready[i]) begin
                if (skid_vld_q[i]) begin
                    vld_d[i]      = 1'b1;
                    pd_d[i]       = skid_pd_q[i];
                    skid_vld_d[i] = 1'b0;
                end else begin
                    vld_d[i] = push_vec[i];
                    if (push_vec[i]) pd_d[i] = bus.dmaif_wr_req_pd;
                end
            end else if (push_vec[i]) begin
                skid_vld_d[i] = 1'b1;
                skid_pd_d[i]  = bus.dmaif_wr_req_pd;
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rel  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        occ_d    = occ_q;
        if (push && !rel)      occ_d = occ_q + OCC_W'(1);
        else if (!push && rel) occ_d = occ_q - OCC_W'(1);
    end

    // Early completions park in cnt until their interface reaches the FIFO head.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q || (bus.dmaif_wr_req_pvld && !sel_ok);
        for (int i = 0; i < NUM_IF; i++) begin
            if (comp_q[i] && !rel_vec[i]) begin
                if (&cnt_q[i]) err_d = 1'b1;
                else           cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!comp_q[i] && rel_vec[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            vld_q      <= '0;
            skid_vld_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            comp_q     <= '0;
            err_q      <= 1'b0;
            rsp_q      <= 1'b0;
            for (int i = 0; i < NUM_IF; i++) begin
                pd_q[i]      <= '0;
                skid_pd_q[i] <= '0;
                cnt_q[i]     <= '0;
            end
        end else begin
            vld_q      <= vld_d;
            skid_vld_q <= skid_vld_d;
            pd_q       <= pd_d;
            skid_pd_q  <= skid_pd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            comp_q     <= bus.if_wr_rsp_complete;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rsp_q      <= rel;
        end
    end

    // NOTE: the ack storage is not reset; occupancy and pointers alone say which entries are live.
    always_ff @(posedge nvdla_core_clk) begin
        if (push) ack_mem_q[wr_ptr_q] <= sel;
    end

    for (genvar g = 0; g < NUM_IF; g++) begin : g_pd
        assign bus.if_wr_req_pd[g*PD_W +: PD_W] = pd_q[g];
    end

    assign bus.dmaif_wr_req_prdy     = prdy;
    assign bus.if_wr_req_valid       = vld_q;
    assign bus.dmaif_wr_rsp_complete = rsp_q;
    assign bus.dmaif_wr_ack_pending  = occ_q;
    assign bus.dmaif_wr_err          = err_q;
endmodule

// File: tb/tb_nv_nvdla_dmaif_wr_router.sv
// Scoreboard bench for the write router: directed requests push expected
// payloads / completion cycles, a negedge monitor pops and compares them.
module tb_nv_nvdla_dmaif_wr_router;
    localparam int NUM_IF = 3;
    localparam int PD_W   = 515;
    localparam int ACK_D  = 4;
    localparam int CNT_W  = 2;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [PD_W-1:0] exp_q [NUM_IF][$];
    int              comp_exp_q[$];
    int              xfer_cnt [NUM_IF];
    logic [NUM_IF-1:0] stall_hold;
    logic [PD_W-1:0] stall_pd [NUM_IF];
    int v1_cnt, v1_first, v1_last, v0_cnt, stall_cnt;

    nv_nvdla_dmaif_wr_router_if #(.NUM_IF(NUM_IF), .PD_W(PD_W), .ACK_DEPTH(ACK_D)) bus ();

    nv_nvdla_dmaif_wr_router #(
        .NUM_IF(NUM_IF), .PD_W(PD_W), .ACK_DEPTH(ACK_D), .CNT_W(CNT_W)
    ) dut (
        .nvdla_core_clk(clk),
        .nvdla_core_rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [PD_W-1:0] mkpd(input int k);
        mkpd = {3'(k + 1), {16{32'(k) ^ 32'hA5A5_0000}}};
    endfunction

    // Holds a request until accepted; returns the negedge cycle of acceptance.
    task automatic send(input int s, input logic [PD_W-1:0] pd, input logic ack,
                        output int acc, output int waits);
        bit done = 0;
        waits = 0;
        acc   = -1;
        bus.reg2dp_dst_ram_type      = 2'(s);
        bus.dmaif_wr_req_pd          = pd;
        bus.dmaif_wr_req_require_ack = ack;
        bus.dmaif_wr_req_pvld        = 1'b1;
        while (!done && waits < 50) begin
            @(negedge clk);
            if (bus.dmaif_wr_req_prdy) begin
                done = 1;
                acc  = cyc;
                exp_q[s].push_back(pd);
            end
            @(posedge clk);
            #1;
            if (!done) waits++;
        end
        bus.dmaif_wr_req_pvld = 1'b0;
        if (!done) check("send_timeout", 64'(waits), 64'(0));
    endtask

    task automatic pulse_cmp(input int i);
        bus.if_wr_rsp_complete[i] = 1'b1;
        tick(1);
        bus.if_wr_rsp_complete[i] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_hold = '0;
        end else begin
            for (int i = 0; i < NUM_IF; i++) begin
                if (stall_hold[i]) begin
                    total++;
                    if (!bus.if_wr_req_valid[i] || bus.if_wr_req_pd[i*PD_W +: PD_W] !== stall_pd[i]) begin
                        bad++;
                        $display("FAIL hold_if%0d: valid=%0b pd changed while stalled (cyc %0d)",
                                 i, bus.if_wr_req_valid[i], cyc);
                    end
                end
                if (bus.if_wr_req_valid[i] && bus.if_wr_req_ready[i]) begin
                    xfer_cnt[i]++;
                    total++;
                    if (exp_q[i].size() == 0) begin
                        bad++;
                        $display("FAIL xfer_if%0d: unexpected transfer, expected none (cyc %0d)", i, cyc);
                    end else begin
                        logic [PD_W-1:0] e;
                        e = exp_q[i].pop_front();
                        if (bus.if_wr_req_pd[i*PD_W +: PD_W] !== e) begin
                            bad++;
                            $display("FAIL pd_if%0d: got %h expected %h",
                                     i, bus.if_wr_req_pd[i*PD_W +: PD_W], e);
                        end
                    end
                end
                stall_hold[i] = bus.if_wr_req_valid[i] && !bus.if_wr_req_ready[i];
                stall_pd[i]   = bus.if_wr_req_pd[i*PD_W +: PD_W];
            end
            if (bus.if_wr_req_valid[1]) begin
                v1_cnt++;
                if (v1_first < 0) v1_first = cyc;
                v1_last = cyc;
            end
            if (bus.if_wr_req_valid[0]) v0_cnt++;
            if (bus.dmaif_wr_req_pvld && !bus.dmaif_wr_req_prdy) stall_cnt++;
            if (bus.dmaif_wr_rsp_complete) begin
                if (comp_exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: completion pulse at cyc %0d, expected none", cyc);
                end else begin
                    check("rsp_cycle", 64'(cyc), 64'(comp_exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int acc, w, wsum, first_acc, c;
        rst = 1'b1;
        bus.reg2dp_dst_ram_type      = '0;
        bus.dmaif_wr_req_pd          = '0;
        bus.dmaif_wr_req_pvld        = 1'b0;
        bus.dmaif_wr_req_require_ack = 1'b0;
        bus.if_wr_req_ready          = '1;
        bus.if_wr_rsp_complete       = '0;
        stall_hold = '0;
        for (int i = 0; i < NUM_IF; i++) xfer_cnt[i] = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(bus.if_wr_req_valid), 64'(0));
        check("rst_prdy", 64'(bus.dmaif_wr_req_prdy), 64'(0));
        check("rst_rsp", 64'(bus.dmaif_wr_rsp_complete), 64'(0));
        check("rst_pending", 64'(bus.dmaif_wr_ack_pending), 64'(0));
        check("rst_err", 64'(bus.dmaif_wr_err), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        tick(1);

        // Back-to-back non-ack burst to interface 1
        v1_cnt = 0; v1_first = -1; v1_last = -1; v0_cnt = 0; wsum = 0; first_acc = -1;
        for (int k = 0; k < 8; k++) begin
            send(1, mkpd(k), 1'b0, acc, w);
            if (k == 0) first_acc = acc;
            wsum += w;
        end
        tick(3);
        check("burst_waits", 64'(wsum), 64'(0));
        check("burst_v1_cycles", 64'(v1_cnt), 64'(8));
        check("burst_latency", 64'(v1_first), 64'(first_acc + 1));
        check("burst_contig", 64'(v1_last - v1_first), 64'(7));
        check("burst_v0_quiet", 64'(v0_cnt), 64'(0));
        check("burst_drained", 64'(exp_q[1].size()), 64'(0));

        // Ready[1] low for 3 cycles mid-burst
        stall_cnt = 0;
        xfer_cnt[1] = 0;
        fork
            for (int k = 0; k < 8; k++) send(1, mkpd(100 + k), 1'b0, acc, w);
            begin
                tick(3);
                bus.if_wr_req_ready[1] = 1'b0;
                tick(3);
                bus.if_wr_req_ready[1] = 1'b1;
            end
        join
        tick(3);
        check("stall_prdy_low", 64'(stall_cnt), 64'(3));
        check("stall_xfers", 64'(xfer_cnt[1]), 64'(8));
        check("stall_drained", 64'(exp_q[1].size()), 64'(0));

        // Out-of-order completions released in issue order
        send(0, mkpd(200), 1'b1, acc, w);
        send(1, mkpd(201), 1'b1, acc, w);
        tick(2);
        @(negedge clk);
        check("ooo_pending2", 64'(bus.dmaif_wr_ack_pending), 64'(2));
        tick(1);
        pulse_cmp(1);
        tick(3);
        c = cyc;
        comp_exp_q.push_back(c + 2);
        comp_exp_q.push_back(c + 3);
        pulse_cmp(0);
        tick(4);
        @(negedge clk);
        check("ooo_pending0", 64'(bus.dmaif_wr_ack_pending), 64'(0));
        check("ooo_all_pulses", 64'(comp_exp_q.size()), 64'(0));
        tick(1);

        // Full ack FIFO backpressures only ack requests
        for (int k = 0; k < 4; k++) send(0, mkpd(300 + k), 1'b1, acc, w);
        bus.reg2dp_dst_ram_type      = 2'd0;
        bus.dmaif_wr_req_pd          = mkpd(500);
        bus.dmaif_wr_req_require_ack = 1'b1;
        bus.dmaif_wr_req_pvld        = 1'b1;
        @(negedge clk);
        check("full_pending", 64'(bus.dmaif_wr_ack_pending), 64'(4));
        check("full_prdy", 64'(bus.dmaif_wr_req_prdy), 64'(0));
        tick(1);
        @(negedge clk);
        check("full_no_overflow", 64'(bus.dmaif_wr_ack_pending), 64'(4));
        tick(1);
        send(0, mkpd(501), 1'b0, acc, w);
        check("full_nonack_flows", 64'(w), 64'(0));
        c = cyc;
        comp_exp_q.push_back(c + 2);
        fork
            pulse_cmp(0);
            send(0, mkpd(500), 1'b1, acc, w);
        join
        check("full_accept_after_release", 64'(acc), 64'(c + 2));
        tick(1);
        @(negedge clk);
        check("refill_pending", 64'(bus.dmaif_wr_ack_pending), 64'(4));
        tick(1);
        c = cyc;
        comp_exp_q.push_back(c + 2);
        pulse_cmp(0);
        tick(2);
        c = cyc;
        comp_exp_q.push_back(c + 2);
        fork
            pulse_cmp(0);
            begin
                tick(1);
                send(0, mkpd(502), 1'b1, acc, w);
            end
        join
        check("pushpop_accept", 64'(acc), 64'(c + 1));
        @(negedge clk);
        check("pushpop_pending", 64'(bus.dmaif_wr_ack_pending), 64'(3));
        tick(1);
        for (int k = 0; k < 3; k++) begin
            comp_exp_q.push_back(cyc + 2);
            pulse_cmp(0);
        end
        tick(4);
        @(negedge clk);
        check("drain_pending", 64'(bus.dmaif_wr_ack_pending), 64'(0));
        check("drain_pulses", 64'(comp_exp_q.size()), 64'(0));
        check("pre_sat_err", 64'(bus.dmaif_wr_err), 64'(0));
        tick(1);

        // Unmatched completions saturate the 2-bit counter at 3
        for (int k = 0; k < 3; k++) pulse_cmp(2);
        tick(2);
        @(negedge clk);
        check("sat3_err", 64'(bus.dmaif_wr_err), 64'(0));
        tick(1);
        pulse_cmp(2);
        tick(2);
        @(negedge clk);
        check("sat4_err", 64'(bus.dmaif_wr_err), 64'(1));
        tick(1);

        // Reset in the middle of a stalled burst
        bus.if_wr_req_ready[1] = 1'b0;
        send(1, mkpd(600), 1'b1, acc, w);
        send(1, mkpd(601), 1'b0, acc, w);
        bus.reg2dp_dst_ram_type = 2'd1;
        bus.dmaif_wr_req_pd     = mkpd(602);
        bus.dmaif_wr_req_pvld   = 1'b1;
        @(negedge clk);
        check("prerst_pending", 64'(bus.dmaif_wr_ack_pending), 64'(1));
        check("prerst_prdy", 64'(bus.dmaif_wr_req_prdy), 64'(0));
        tick(1);
        #1 rst = 1'b1;
        exp_q[1].delete();
        #1;
        check("rst_mid_valid", 64'(bus.if_wr_req_valid), 64'(0));
        check("rst_mid_pd", 64'(|bus.if_wr_req_pd), 64'(0));
        check("rst_mid_prdy", 64'(bus.dmaif_wr_req_prdy), 64'(0));
        check("rst_mid_pending", 64'(bus.dmaif_wr_ack_pending), 64'(0));
        check("rst_mid_err", 64'(bus.dmaif_wr_err), 64'(0));
        check("rst_mid_rsp", 64'(bus.dmaif_wr_rsp_complete), 64'(0));
        bus.dmaif_wr_req_pvld  = 1'b0;
        bus.if_wr_req_ready[1] = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);

        // Counters were cleared: an ack to if2 waits for its own completion
        send(2, mkpd(700), 1'b1, acc, w);
        tick(5);
        @(negedge clk);
        check("postrst_pending", 64'(bus.dmaif_wr_ack_pending), 64'(1));
        tick(1);
        comp_exp_q.push_back(cyc + 2);
        pulse_cmp(2);
        tick(4);
        @(negedge clk);
        check("postrst_drain", 64'(bus.dmaif_wr_ack_pending), 64'(0));
        tick(1);

        // Out-of-range destination: never accepted, sticky error
        bus.reg2dp_dst_ram_type      = 2'd3;
        bus.dmaif_wr_req_pd          = mkpd(800);
        bus.dmaif_wr_req_require_ack = 1'b0;
        bus.dmaif_wr_req_pvld        = 1'b1;
        @(negedge clk);
        check("badsel_prdy", 64'(bus.dmaif_wr_req_prdy), 64'(0));
        check("badsel_err_before", 64'(bus.dmaif_wr_err), 64'(0));
        tick(1);
        @(negedge clk);
        check("badsel_err_set", 64'(bus.dmaif_wr_err), 64'(1));
        tick(1);
        bus.dmaif_wr_req_pvld = 1'b0;
        tick(3);
        @(negedge clk);
        check("badsel_err_sticky", 64'(bus.dmaif_wr_err), 64'(1));
        check("badsel_no_valid", 64'(bus.if_wr_req_valid), 64'(0));
        tick(2);

        for (int i = 0; i < NUM_IF; i++) check("final_exp_empty", 64'(exp_q[i].size()), 64'(0));
        check("final_rsp_empty", 64'(comp_exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
